// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive buffer: frame alignment, parity check, show-ahead FIFO, overrun/timeout status
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TO_CYCLES  = 1024,
    parameter int TO_W       = 11
) (
    input  logic                  SCLK,
    input  logic                  SCLR,
    input  logic [2:0]            UMODE,
    input  logic                  RX_STB,
    input  logic [8:0]            RX_DATA,
    input  logic                  RX_ERR,
    input  logic                  RD_EN,
    output logic [7:0]            RD_DATA,
    output logic                  RD_PERR,
    output logic                  RD_ERR,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  OVERRUN,
    input  logic                  CLR_OVR,
    output logic                  TIMEOUT
);

    localparam int                 DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_MAX = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [TO_W-1:0]    TO_MAX  = TO_W'(TO_CYCLES);
    localparam logic [TO_W-1:0]    TO_ONE  = TO_W'(1);

    logic [9:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_ovr;
    logic [TO_W-1:0]       r_to_cnt;

    logic [3:0]            w_n;
    logic [3:0]            w_t;
    logic [3:0]            w_shift;
    logic [8:0]            w_a;
    logic [7:0]            w_mask;
    logic [7:0]            w_data;
    logic                  w_par_bit;
    logic                  w_perr;
    logic [9:0]            w_entry;
    logic [9:0]            w_head;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_drop;

    // Frame alignment: the frame occupies the top t bits of the receiver shift register.
    assign w_n       = 4'd5 + {2'b00, UMODE[2:1]};
    assign w_t       = w_n + {3'b000, UMODE[0]};
    assign w_shift   = 4'd9 - w_t;
    assign w_a       = RX_DATA >> w_shift;
    assign w_mask    = 8'hFF >> (4'd8 - w_n);
    assign w_data    = w_a[7:0] & w_mask;
    assign w_par_bit = w_a[w_n];
    assign w_perr    = UMODE[0] & ((^w_data) != w_par_bit);
    assign w_entry   = {RX_ERR, w_perr, w_data};

    assign EMPTY   = (r_count == '0);
    assign FULL    = (r_count == CNT_MAX);
    assign COUNT   = r_count;
    assign OVERRUN = r_ovr;
    assign TIMEOUT = (r_to_cnt == TO_MAX) & ~EMPTY;

    // A pop in the same cycle frees the slot, so a strobe at full is still accepted.
    assign w_pop  = RD_EN & ~EMPTY;
    assign w_wr   = RX_STB & (~FULL | w_pop);
    assign w_drop = RX_STB & FULL & ~w_pop;

    assign w_head  = r_mem[r_rd_ptr];
    assign RD_DATA = EMPTY ? 8'h00 : w_head[7:0];
    assign RD_PERR = EMPTY ? 1'b0  : w_head[8];
    assign RD_ERR  = EMPTY ? 1'b0  : w_head[9];

    always_ff @(posedge SCLK) begin
        if (!SCLR && w_wr) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge SCLK) begin
        if (SCLR) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_wr) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // A drop and a clear in the same cycle leave the flag set.
    always_ff @(posedge SCLK) begin
        if (SCLR) begin
            r_ovr <= 1'b0;
        end else if (w_drop) begin
            r_ovr <= 1'b1;
        end else if (CLR_OVR) begin
            r_ovr <= 1'b0;
        end
    end

    always_ff @(posedge SCLK) begin
        if (SCLR) begin
            r_to_cnt <= '0;
        end else if (EMPTY || w_wr || w_pop) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TO_MAX) begin
            r_to_cnt <= r_to_cnt + TO_ONE;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue-based reference model
module tb_uart_rx_fifo;

    localparam int TO_CYC = 8;

    logic       SCLK = 1'b0;
    logic       SCLR = 1'b1;
    logic [2:0] UMODE = 3'b000;
    logic       RX_STB = 1'b0;
    logic [8:0] RX_DATA = 9'h000;
    logic       RX_ERR = 1'b0;
    logic       RD_EN = 1'b0;
    logic       CLR_OVR = 1'b0;
    logic [7:0] RD_DATA;
    logic       RD_PERR;
    logic       RD_ERR;
    logic       EMPTY;
    logic       FULL;
    logic [4:0] COUNT;
    logic       OVERRUN;
    logic       TIMEOUT;

    int checks = 0;
    int errors = 0;

    logic [9:0] mq[$];
    logic       m_ovr = 1'b0;
    int         m_idle = 0;

    uart_rx_fifo #(.DEPTH_LOG2(4), .TO_CYCLES(TO_CYC), .TO_W(4)) dut (
        .SCLK(SCLK), .SCLR(SCLR), .UMODE(UMODE), .RX_STB(RX_STB),
        .RX_DATA(RX_DATA), .RX_ERR(RX_ERR), .RD_EN(RD_EN),
        .RD_DATA(RD_DATA), .RD_PERR(RD_PERR), .RD_ERR(RD_ERR),
        .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT), .OVERRUN(OVERRUN),
        .CLR_OVR(CLR_OVR), .TIMEOUT(TIMEOUT)
    );

    always #5 SCLK = ~SCLK;

    function automatic logic [9:0] ref_entry(input logic [2:0] m, input logic [8:0] d, input logic e);
        int n, p, t, a, data, par, perr;
        n    = 5 + int'(m[2:1]);
        p    = int'(m[0]);
        t    = n + p;
        a    = int'(d) / (1 << (9 - t));
        data = a % (1 << n);
        par  = (a / (1 << n)) % 2;
        perr = (p == 1 && ($countones(data) % 2) != par) ? 1 : 0;
        return {e, perr[0], data[7:0]};
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = mq.size();
        check({tag, ".count"},   int'(COUNT),   sz);
        check({tag, ".empty"},   int'(EMPTY),   (sz == 0) ? 1 : 0);
        check({tag, ".full"},    int'(FULL),    (sz == 16) ? 1 : 0);
        check({tag, ".rd_data"}, int'(RD_DATA), (sz > 0) ? int'(mq[0][7:0]) : 0);
        check({tag, ".rd_perr"}, int'(RD_PERR), (sz > 0) ? int'(mq[0][8]) : 0);
        check({tag, ".rd_err"},  int'(RD_ERR),  (sz > 0) ? int'(mq[0][9]) : 0);
        check({tag, ".overrun"}, int'(OVERRUN), int'(m_ovr));
        check({tag, ".timeout"}, int'(TIMEOUT), (sz > 0 && m_idle == TO_CYC) ? 1 : 0);
    endtask

    task automatic step(input string tag, input logic stb, input logic [2:0] m, input logic [8:0] d,
                        input logic e, input logic rd, input logic clr, input logic rst);
        bit was_empty, pop, wr;
        SCLR = rst; RX_STB = stb; UMODE = m; RX_DATA = d; RX_ERR = e; RD_EN = rd; CLR_OVR = clr;
        was_empty = (mq.size() == 0);
        pop = rd && !was_empty;
        wr  = stb && (mq.size() < 16 || pop);
        if (rst) begin
            mq.delete();
            m_ovr  = 1'b0;
            m_idle = 0;
        end else begin
            if (stb && !wr) m_ovr = 1'b1;
            else if (clr)   m_ovr = 1'b0;
            if (was_empty || wr || pop) m_idle = 0;
            else if (m_idle < TO_CYC)   m_idle++;
            if (pop) void'(mq.pop_front());
            if (wr)  mq.push_back(ref_entry(m, d, e));
        end
        @(posedge SCLK);
        #1;
        SCLR = 1'b0; RX_STB = 1'b0; RD_EN = 1'b0; CLR_OVR = 1'b0;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 3'b000, 9'h0, 0, 0, 0, 0);
    endtask

    initial begin
        step("reset", 0, 3'b000, 9'h0, 0, 0, 0, 1);

        step("t1_wr", 1, 3'b111, 9'h1A5, 0, 0, 0, 0);
        check("t1_data_const", int'(RD_DATA), 8'hA5);
        check("t1_perr_const", int'(RD_PERR), 1);
        step("t1_rd", 0, 3'b000, 9'h0, 0, 1, 0, 0);

        step("t2a", 1, 3'b000, 9'b101100000, 0, 0, 0, 0);
        check("t2a_data_const", int'(RD_DATA), 8'h16);
        step("t2a_rd", 0, 3'b000, 9'h0, 0, 1, 0, 0);
        step("t2b", 1, 3'b001, 9'b110110000, 1, 0, 0, 0);
        check("t2b_data_const", int'(RD_DATA), 8'h16);
        check("t2b_perr_const", int'(RD_PERR), 0);
        step("t2b_rd", 0, 3'b000, 9'h0, 0, 1, 0, 0);

        for (int i = 0; i < 16; i++) step("t3_fill", 1, 3'b110, 9'(i << 1), 0, 0, 0, 0);
        check("t3_full_const", int'(FULL), 1);
        step("t3_drop", 1, 3'b110, 9'h1FE, 0, 0, 0, 0);
        check("t3_ovr_const", int'(OVERRUN), 1);
        for (int i = 0; i < 16; i++) begin
            check("t3_order", int'(RD_DATA), i);
            step("t3_drain", 0, 3'b000, 9'h0, 0, 1, 0, 0);
        end
        step("t3_clr", 0, 3'b000, 9'h0, 0, 0, 1, 0);

        for (int i = 0; i < 16; i++) step("t4_fill", 1, 3'b110, 9'((i + 32) << 1), i[0], 0, 0, 0);
        step("t4_wrpop_full", 1, 3'b110, 9'h0AA, 0, 1, 0, 0);
        for (int i = 0; i < 15; i++) step("t4_drain", 0, 3'b000, 9'h0, 0, 1, 0, 0);
        check("t4_last_const", int'(RD_DATA), 8'h55);
        step("t4_wrpop_one", 1, 3'b111, 9'h0F3, 1, 1, 0, 0);
        check("t4_empty_const", int'(EMPTY), 0);
        step("t4_rd", 0, 3'b000, 9'h0, 0, 1, 0, 0);

        step("t5_wr", 1, 3'b100, 9'h1C0, 0, 0, 0, 0);
        idle("t5_idle", 10);
        check("t5_to_const", int'(TIMEOUT), 1);
        step("t5_rd", 0, 3'b000, 9'h0, 0, 1, 0, 0);
        idle("t5_empty_idle", 20);

        for (int i = 0; i < 5; i++) step("t6_fill", 1, 3'b011, 9'($urandom), 0, 0, 0, 0);
        m_ovr = 1'b0;
        for (int i = 0; i < 11; i++) step("t6_fill2", 1, 3'b011, 9'($urandom), 0, 0, 0, 0);
        step("t6_drop", 1, 3'b011, 9'h155, 0, 0, 1, 0);
        step("t6_rst", 1, 3'b111, 9'h1FF, 1, 1, 0, 1);
        check("t6_empty_const", int'(EMPTY), 1);

        for (int i = 0; i < 600; i++) begin
            logic stb, rd, clr, e;
            logic [2:0] m;
            logic [8:0] d;
            stb = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 25));
            rd  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 25 : 60));
            clr = ($urandom_range(0, 99) < 5);
            e   = 1'($urandom);
            m   = 3'($urandom);
            d   = 9'($urandom);
            if (i % 150 == 149) idle("rnd_idle", 12);
            step("rnd", stb, m, d, e, rd, clr, ($urandom_range(0, 299) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver. It captures each completed frame on the receiver's completion strobe and right-justifies the data to the configured word length. It recomputes parity, tags each frame with error flags and queues it in a show-ahead FIFO for the host/bus side. It also raises overrun and idle-timeout status.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (depth = 16 entries)
TO_CYCLES, 1024, SCLK cycles of inactivity with FIFO non-empty before TIMEOUT asserts (must be >= 1)
TO_W, 11, width of timeout counter (2^TO_W > TO_CYCLES)

Ports:
SCLK  in  1  system clock, all logic on rising edge
SCLR  in  1  synchronous active-high reset
UMODE  in  3  frame format: data bits = 5 + UMODE[2:1], parity present = UMODE[0]
RX_STB  in  1  one-cycle strobe from receiver: frame complete, RX_DATA/RX_ERR valid this cycle
RX_DATA  in  9  raw receiver shift register; first-received bit lands lowest after alignment
RX_ERR  in  1  receiver error flag (framing or parity) for this frame
RD_EN  in  1  pop head entry
RD_DATA  out  8  head entry data, right-justified, zero-extended
RD_PERR  out  1  head entry recomputed parity error
RD_ERR  out  1  head entry RX_ERR copy
EMPTY  out  1  FIFO empty
FULL  out  1  FIFO full
COUNT  out  DEPTH_LOG2+1  entries held (0..16)
OVERRUN  out  1  sticky: frame dropped because FIFO full
CLR_OVR  in  1  clears OVERRUN
TIMEOUT  out  1  FIFO non-empty and idle TO_CYCLES cycles

Behaviour:
- Reset (SCLR=1 at edge): wr/rd pointers 0, COUNT=0, EMPTY=1, FULL=0, OVERRUN=0, TIMEOUT=0, timeout counter 0, RD_DATA=0, RD_PERR=0, RD_ERR=0. Reset mid-frame discards all entries; SCLR has priority over every other input.
- Alignment (combinational on the strobe cycle, UMODE sampled only then):
  - n = 5+UMODE[2:1]; p = UMODE[0]; t = n+p.
  - A = RX_DATA >> (9-t).
  - data = A[n-1:0] zero-extended to 8 bits.
  - parity bit = A[n] when p=1.
- Parity: even. PERR = p & (^data != parity bit). PERR = 0 when p=0.
- Entry stored: {RX_ERR, PERR, data} = 10 bits. Storage is a register array of 2^DEPTH_LOG2 entries; pointers DEPTH_LOG2 bits, wrap modulo depth.
- Write: RX_STB=1 and (!FULL or RD_EN pop accepted same cycle) → entry written at wr_ptr, wr_ptr+1.
- Full drop: RX_STB=1, FULL=1, no pop → frame dropped; OVERRUN<=1 at that edge.
- Read: RD_EN=1 and !EMPTY → rd_ptr+1. RD_EN while EMPTY is ignored (no pointer or count change).
- COUNT: +1 on write only, -1 on pop only, unchanged on simultaneous write+pop (including at full and at count=1). EMPTY = (COUNT==0), FULL = (COUNT==depth), both registered/derived same cycle as COUNT.
- Latency: frame strobed at edge k is visible on RD_* with EMPTY=0 in the cycle after edge k. Simultaneous write+pop with COUNT=1: the new entry becomes head next cycle and EMPTY stays 0.
- Show-ahead: RD_DATA/RD_PERR/RD_ERR continuously present the head entry when !EMPTY. They are 0 when EMPTY.
- OVERRUN: sticky until CLR_OVR=1 (cleared at that edge). Simultaneous drop and CLR_OVR → OVERRUN=1 (set wins).
- Timeout counter:
  - Cleared when EMPTY, on any accepted write, on any accepted pop; otherwise increments, saturating at TO_CYCLES.
  - TIMEOUT = (counter == TO_CYCLES) & !EMPTY. Deasserts on the edge of the clearing event.

Test Plan:
1. UMODE=3'b111, RX_DATA=9'h1A5 (parity 1, data A5, 4 ones) strobe → next cycle EMPTY=0, COUNT=1, RD_DATA=8'hA5, RD_PERR=1. Then RD_EN → EMPTY=1, RD_DATA=0.
2. UMODE=3'b000, RX_DATA=9'b10110_0000 → RD_DATA=8'h16, RD_PERR=0. UMODE=3'b001, RX_DATA=9'b1_10110_000 → RD_DATA=8'h16, parity 1 vs 3 ones → RD_PERR=0.
3. 16 strobes data 0..15 → FULL=1, COUNT=16. 17th strobe → dropped, OVERRUN=1. Drain reads 0..15 in order, pointer wrap verified. CLR_OVR → OVERRUN=0.
4. At FULL, strobe 8'h55 with RD_EN same cycle → COUNT stays 16, OVERRUN=0, 8'h55 read last. At COUNT=1, simultaneous write+pop → EMPTY stays 0, new entry at head.
5. TO_CYCLES=8: one write then idle → TIMEOUT=1 exactly 8 cycles later. RD_EN → TIMEOUT=0 and EMPTY=1. With EMPTY idle, TIMEOUT never asserts.
6. Fill 5 entries, OVERRUN set, then SCLR mid-stream with RX_STB=1 → all outputs at reset values next cycle, strobe ignored.
